add_seq_64: RTL and testbench
=============================

ADD_SEQ_64 -- requirements
Module: add_seq_64

Interface
REQ-001 SHALL provide parameter SLICE_W, default 16, bits added per cycle; legal values 8, 16, 32, 64; NS = 64/SLICE_W.
REQ-002 SHALL provide port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port start  input  1  request; sampled only when not busy.
REQ-005 SHALL provide port a  input  64  signed augend; sampled with accepted start.
REQ-006 SHALL provide port b  input  64  signed addend; sampled with accepted start.
REQ-007 SHALL provide port sum  output  64  registered result a+b mod 2^64.
REQ-008 SHALL provide port carry  output  1  carry out of bit 63.
REQ-009 SHALL provide port overflow  output  1  signed two's-complement overflow.
REQ-010 SHALL provide port zf  output  1  sum == 0.
REQ-011 SHALL provide port sf  output  1  sum[63].
REQ-012 SHALL provide port busy  output  1  operation in progress; start ignored while high.
REQ-013 SHALL provide port done  output  1  one-cycle pulse; results valid.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE or DONE with start=1 at an edge SHALL latch a, b, clear internal carry to 0, clear slice index to 0, and enter RUN.
REQ-016 IDLE or DONE with start=0 SHALL go to (or remain in) IDLE.
REQ-017 Each RUN edge SHALL add slice i (bits i*SLICE_W+SLICE_W-1 : i*SLICE_W) of the latched operands plus internal carry, store the slice into an internal accumulator, update the internal carry, and increment i.
REQ-018 The RUN edge processing slice NS-1 SHALL transfer the accumulator and flags to the outputs and enter DONE.
REQ-019 Latency: start accepted at edge k -> done=1 and outputs valid in the cycle following edge k+NS (4 cycles with default).
REQ-020 busy SHALL be 1 exactly while in RUN.
REQ-021 done SHALL be 1 exactly while in DONE, i.e. for one cycle per operation.
REQ-022 start while busy=1 SHALL be ignored; it SHALL have no effect on operands, timing, or results.
REQ-023 start during the DONE cycle SHALL be accepted: back-to-back throughput is one result per NS+1 cycles.
REQ-024 overflow SHALL equal (a[63]==b[63]) AND (sum[63]!=a[63]), using latched operands.
REQ-025 carry SHALL be the carry out of the final slice.
REQ-026 zf and sf SHALL be computed from the full 64-bit result.
REQ-027 sum, carry, overflow, zf and sf SHALL update only on the final-slice edge and hold between results; they SHALL not show partial sums during RUN.
REQ-028 Input changes on a or b after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, sum=0, carry=0, overflow=0, zf=0, sf=0, and the internal carry and index cleared.
REQ-030 rst SHALL take priority over start and over any RUN activity.
REQ-031 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted operation.

Verification (SLICE_W=16)
REQ-032 Apply a=1, b=1, start for 1 cycle -> busy for 4 cycles, then done=1 for 1 cycle with sum=2 and carry=overflow=zf=sf=0.
REQ-033 Apply a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, overflow=1, sf=1, carry=0, zf=0.
REQ-034 Apply a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, carry=1, zf=1, overflow=0 (carry propagates through all 4 slices).
REQ-035 Apply a=b=0x8000_0000_0000_0000 -> sum=0, carry=1, overflow=1, zf=1, sf=0.
REQ-036 Re-pulse start and change a/b during RUN -> no effect on timing or result; start in the done cycle -> second done exactly 5 cycles after the first.
REQ-037 Assert rst in the 2nd RUN cycle -> next cycle busy=0 and all outputs 0; no done pulse; the next start yields a correct result.

Source files
------------

// File: rtl/add_seq_64.sv
// add_seq_64: multi-cycle 64-bit signed adder, one SLICE_W-bit slice per clock with status flags
module add_seq_64 #(
    parameter int SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        carry,
    output logic        overflow,
    output logic        zf,
    output logic        sf,
    output logic        busy,
    output logic        done
);
    localparam int NS = 64 / SLICE_W;
    localparam int IW = NS > 1 ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic [63:0]         op_a, op_b, acc, acc_nx;
    logic [IW-1:0]       idx;
    logic                cin;
    logic [SLICE_W-1:0]  a_sl, b_sl;
    logic [SLICE_W:0]    sl_sum;
    logic [6:0]          sh;
    logic                last, accept;

    // current slice adder and accumulator merge
    always_comb begin
        sh = 7'(idx) * 7'(SLICE_W);
        a_sl = op_a[sh +: SLICE_W];
        b_sl = op_b[sh +: SLICE_W];
        sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, cin};
        acc_nx = acc;
        acc_nx[sh +: SLICE_W] = sl_sum[SLICE_W-1:0];
        last = idx == IW'(NS - 1);
        accept = start && state != RUN;
    end

    // next state and status outputs; a new request may also be taken in DONE
    always_comb begin
        state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        busy = state == RUN;
        done = state == DONE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // operand capture, slice iteration and result publication on the final slice
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cin      <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zf       <= 1'b0;
            sf       <= 1'b0;
        end else if (accept) begin
            op_a <= a;
            op_b <= b;
            cin  <= 1'b0;
            idx  <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            cin <= sl_sum[SLICE_W];
            idx <= last ? '0 : idx + 1'b1;
            if (last) begin
                sum      <= acc_nx;
                carry    <= sl_sum[SLICE_W];
                overflow <= (op_a[63] == op_b[63]) && (acc_nx[63] != op_a[63]);
                zf       <= acc_nx == 64'd0;
                sf       <= acc_nx[63];
            end
        end
    end
endmodule

// File: tb/tb_add_seq_64.sv
// tb_add_seq_64: directed self-checking bench for add_seq_64 with SLICE_W=16
module tb_add_seq_64;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [63:0] sum;
    logic        carry, overflow, zf, sf, busy, done;
    int          checks = 0;
    int          errors = 0;

    add_seq_64 #(.SLICE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sum(sum),
        .carry(carry), .overflow(overflow), .zf(zf), .sf(sf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [63:0] va, input logic [63:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        a = 64'd5;
        b = 64'd6;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, carry, overflow, zf, sf} !== 70'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h c=%b v=%b z=%b s=%b, want all 0",
                     busy, done, sum, carry, overflow, zf, sf);
        end
    endtask

    task automatic test_basic;
        launch(64'd1, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 64'd0) begin
                errors++;
                $display("FAIL basic_run%0d: busy=%b done=%b sum=%h, want busy=1 done=0 sum=0", i, busy, done, sum);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 64'd2 || {carry, overflow, zf, sf} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b sum=%h cvzs=%b%b%b%b, want done=1 busy=0 sum=2 cvzs=0000",
                     done, busy, sum, carry, overflow, zf, sf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 64'd2) begin
            errors++;
            $display("FAIL basic_hold: done=%b busy=%b sum=%h, want done=0 busy=0 sum=2", done, busy, sum);
        end
    endtask

    task automatic test_vectors;
        logic [63:0] va [7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                64'h0000_FFFF_0000_FFFF};
        logic [63:0] vb [7] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001};
        logic [63:0] vs [7] = '{64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0000_0000_0001_0000,
                                64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0001_0000_0001_0000};
        logic [3:0]  vf [7] = '{4'b0101, 4'b1010, 4'b1110, 4'b0000, 4'b1001, 4'b1100, 4'b0000};
        int n;
        for (int i = 0; i < 7; i++) begin
            launch(va[i], vb[i]);
            wait_done(n);
            checks++;
            if (n !== 5 || sum !== vs[i] || {carry, overflow, zf, sf} !== vf[i]) begin
                errors++;
                $display("FAIL vec%0d: cycles=%0d sum=%h cvzs=%b%b%b%b, want cycles=5 sum=%h cvzs=%b",
                         i, n, sum, carry, overflow, zf, sf, vs[i], vf[i]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        launch(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 64'hFFFF_FFFF_FFFF_FFFF;
            b = 64'hFFFF_FFFF_FFFF_FFFF;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n = 4;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 5 || sum !== 64'h1234_5678_9ABC_DF00 || {carry, overflow, zf, sf} !== 4'b0000) begin
            errors++;
            $display("FAIL busy_ignore: cycles=%0d sum=%h cvzs=%b%b%b%b, want cycles=5 sum=123456789abcdf00 cvzs=0000",
                     n, sum, carry, overflow, zf, sf);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        launch(64'd2, 64'd3);
        wait_done(n);
        checks++;
        if (n !== 5 || sum !== 64'd5) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d sum=%h, want cycles=5 sum=5", n, sum);
        end
        a = 64'd10;
        b = 64'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sum !== 64'd5) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b sum=%h, want busy=1 sum=5", busy, sum);
        end
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 5 || sum !== 64'd30) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d sum=%h, want cycles=5 sum=30", n, sum);
        end
    endtask

    task automatic test_reset_abort;
        int n;
        int seen;
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(n);
        checks++;
        if (n !== 5 || sum !== 64'hFFFF_FFFF_FFFF_FFFE || {carry, sf} !== 2'b11) begin
            errors++;
            $display("FAIL abort_pre: cycles=%0d sum=%h c=%b s=%b, want cycles=5 sum=fffffffffffffffe c=1 s=1",
                     n, sum, carry, sf);
        end
        launch(64'h1234, 64'h4321);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, carry, overflow, zf, sf} !== 70'd0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b sum=%h cvzs=%b%b%b%b, want all 0",
                     busy, done, sum, carry, overflow, zf, sf);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles=%0d, want 0", seen);
        end
        launch(64'd5, 64'd7);
        wait_done(n);
        checks++;
        if (n !== 5 || sum !== 64'd12 || {carry, overflow, zf, sf} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_recover: cycles=%0d sum=%h cvzs=%b%b%b%b, want cycles=5 sum=c cvzs=0000",
                     n, sum, carry, overflow, zf, sf);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_busy_ignore;
        test_back_to_back;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
